// File: rtl/rv_ctrl_pipe.sv
// RV32I control path: decodes op/funct3/funct7 in D and carries the control bundle through E/M/W.
// Optional macro RV_MULDIV_EN adds decoding of mul/mulh/div/rem (funct7 = 0000001).
module rv_ctrl_pipe #(
  parameter int IMMSRC_W = 3,
  parameter int ALUCTL_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_d,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                flush_e,
  input  logic                zero_e,
  input  logic                lt_e,
  output logic [IMMSRC_W-1:0] imm_src_d,
  output logic                illegal_d,
  output logic                reg_write_e,
  output logic                reg_write_m,
  output logic                reg_write_w,
  output logic [1:0]          result_src_e,
  output logic [1:0]          result_src_m,
  output logic [1:0]          result_src_w,
  output logic                mem_write_e,
  output logic                mem_write_m,
  output logic                alu_src_e,
  output logic [ALUCTL_W-1:0] alu_ctl_e,
  output logic                jalr_e,
  output logic                pc_src_e,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [ALUCTL_W-1:0] ALU_ADD   = ALUCTL_W'(0);
  localparam logic [ALUCTL_W-1:0] ALU_SUB   = ALUCTL_W'(1);
  localparam logic [ALUCTL_W-1:0] ALU_AND   = ALUCTL_W'(2);
  localparam logic [ALUCTL_W-1:0] ALU_OR    = ALUCTL_W'(3);
  localparam logic [ALUCTL_W-1:0] ALU_XOR   = ALUCTL_W'(4);
  localparam logic [ALUCTL_W-1:0] ALU_SLT   = ALUCTL_W'(5);
  localparam logic [ALUCTL_W-1:0] ALU_SLTU  = ALUCTL_W'(6);
  localparam logic [ALUCTL_W-1:0] ALU_SLL   = ALUCTL_W'(7);
  localparam logic [ALUCTL_W-1:0] ALU_SRL   = ALUCTL_W'(8);
  localparam logic [ALUCTL_W-1:0] ALU_SRA   = ALUCTL_W'(9);
  localparam logic [ALUCTL_W-1:0] ALU_PASSB = ALUCTL_W'(10);

  // alt selects sub/sra in place of add/srl
  function automatic logic [ALUCTL_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic                dec_rw, dec_mw, dec_as, dec_jump, dec_jalr, dec_br, unsup;
  logic [1:0]          dec_rs;
  logic [ALUCTL_W-1:0] dec_alu;
  logic [IMMSRC_W-1:0] dec_imm;

  always_comb begin
    dec_rw = 1'b0; dec_rs = 2'b00; dec_mw = 1'b0; dec_as = 1'b0;
    dec_alu = ALU_ADD; dec_jump = 1'b0; dec_jalr = 1'b0; dec_br = 1'b0;
    dec_imm = IMMSRC_W'(0); unsup = 1'b0;
    case (op)
      7'b0110011: begin
        dec_rw = 1'b1;
        case (funct7)
          7'b0000000, 7'b0100000: dec_alu = arith_op(funct3, funct7[5]);
`ifdef RV_MULDIV_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  dec_alu = ALUCTL_W'(11);
              3'b001:  dec_alu = ALUCTL_W'(12);
              3'b100:  dec_alu = ALUCTL_W'(13);
              3'b110:  dec_alu = ALUCTL_W'(14);
              default: unsup = 1'b1;
            endcase
          end
`endif
          default: unsup = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_rw = 1'b1; dec_as = 1'b1;
        dec_alu = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
        // Only shift-immediates interpret funct7; srai alone may set bit 5
        if (funct3 == 3'b001 && funct7 != 7'b0000000) unsup = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) unsup = 1'b1;
      end
      7'b0000011: begin
        dec_rw = 1'b1; dec_rs = 2'b01; dec_as = 1'b1;
        unsup = (funct3 != 3'b010);
      end
      7'b0100011: begin
        dec_mw = 1'b1; dec_as = 1'b1; dec_imm = IMMSRC_W'(1);
        unsup = (funct3 != 3'b010);
      end
      7'b1100011: begin
        dec_br = 1'b1; dec_alu = ALU_SUB; dec_imm = IMMSRC_W'(2);
        unsup = (funct3 == 3'b010) || (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b1101111: begin
        dec_rw = 1'b1; dec_rs = 2'b10; dec_jump = 1'b1; dec_imm = IMMSRC_W'(4);
      end
      7'b1100111: begin
        dec_rw = 1'b1; dec_rs = 2'b10; dec_jump = 1'b1; dec_jalr = 1'b1; dec_as = 1'b1;
      end
      7'b0110111: begin
        dec_rw = 1'b1; dec_as = 1'b1; dec_alu = ALU_PASSB; dec_imm = IMMSRC_W'(3);
      end
      default: unsup = 1'b1;
    endcase
    illegal_d = valid_d && unsup;
    if (!valid_d || unsup) begin
      dec_rw = 1'b0; dec_rs = 2'b00; dec_mw = 1'b0; dec_as = 1'b0;
      dec_alu = ALU_ADD; dec_jump = 1'b0; dec_jalr = 1'b0; dec_br = 1'b0;
      dec_imm = IMMSRC_W'(0);
    end
  end

  assign imm_src_d = dec_imm;

  logic                reg_write_e_q, reg_write_m_q, reg_write_w_q;
  logic [1:0]          result_src_e_q, result_src_m_q, result_src_w_q;
  logic                mem_write_e_q, mem_write_m_q, alu_src_e_q, jump_e_q, jalr_e_q, branch_e_q;
  logic [ALUCTL_W-1:0] alu_ctl_e_q;
  logic [2:0]          br_cond_e_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign cnt_d = (illegal_d && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_e_q <= 1'b0; result_src_e_q <= 2'b00; mem_write_e_q <= 1'b0;
      alu_src_e_q <= 1'b0; alu_ctl_e_q <= '0; jump_e_q <= 1'b0; jalr_e_q <= 1'b0;
      branch_e_q <= 1'b0; br_cond_e_q <= 3'b000;
      reg_write_m_q <= 1'b0; result_src_m_q <= 2'b00; mem_write_m_q <= 1'b0;
      reg_write_w_q <= 1'b0; result_src_w_q <= 2'b00;
      cnt_q <= '0;
    end else begin
      // D -> E: a flush loads a bubble
      if (flush_e) begin
        reg_write_e_q <= 1'b0; result_src_e_q <= 2'b00; mem_write_e_q <= 1'b0;
        alu_src_e_q <= 1'b0; alu_ctl_e_q <= '0; jump_e_q <= 1'b0; jalr_e_q <= 1'b0;
        branch_e_q <= 1'b0; br_cond_e_q <= 3'b000;
      end else begin
        reg_write_e_q <= dec_rw; result_src_e_q <= dec_rs; mem_write_e_q <= dec_mw;
        alu_src_e_q <= dec_as; alu_ctl_e_q <= dec_alu; jump_e_q <= dec_jump;
        jalr_e_q <= dec_jalr; branch_e_q <= dec_br; br_cond_e_q <= funct3;
      end
      // E -> M -> W
      reg_write_m_q <= reg_write_e_q; result_src_m_q <= result_src_e_q; mem_write_m_q <= mem_write_e_q;
      reg_write_w_q <= reg_write_m_q; result_src_w_q <= result_src_m_q;
      cnt_q <= cnt_d;
    end
  end

  logic taken;
  always_comb begin
    case (br_cond_e_q)
      3'b000:  taken = zero_e;
      3'b001:  taken = !zero_e;
      3'b100:  taken = lt_e;
      3'b101:  taken = !lt_e;
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_e     = jump_e_q || (branch_e_q && taken);
  assign reg_write_e  = reg_write_e_q;
  assign reg_write_m  = reg_write_m_q;
  assign reg_write_w  = reg_write_w_q;
  assign result_src_e = result_src_e_q;
  assign result_src_m = result_src_m_q;
  assign result_src_w = result_src_w_q;
  assign mem_write_e  = mem_write_e_q;
  assign mem_write_m  = mem_write_m_q;
  assign alu_src_e    = alu_src_e_q;
  assign alu_ctl_e    = alu_ctl_e_q;
  assign jalr_e       = jalr_e_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Directed self-checking bench for rv_ctrl_pipe (default parameters).
module tb_rv_ctrl_pipe;
  logic       clk, rst_n, valid_d, flush_e, zero_e, lt_e;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic [2:0] imm_src_d;
  logic       illegal_d, reg_write_e, reg_write_m, reg_write_w;
  logic [1:0] result_src_e, result_src_m, result_src_w;
  logic       mem_write_e, mem_write_m, alu_src_e, jalr_e, pc_src_e;
  logic [3:0] alu_ctl_e;
  logic [7:0] illegal_cnt;

  int npass = 0, ntotal = 0;
  int exp_cnt = 0;

  rv_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .op(op), .funct3(funct3), .funct7(funct7),
    .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .imm_src_d(imm_src_d), .illegal_d(illegal_d),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .result_src_m(result_src_m), .result_src_w(result_src_w),
    .mem_write_e(mem_write_e), .mem_write_m(mem_write_m), .alu_src_e(alu_src_e),
    .alu_ctl_e(alu_ctl_e), .jalr_e(jalr_e), .pc_src_e(pc_src_e), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [31:0] ins);
    op = ins[6:0]; funct3 = ins[14:12]; funct7 = ins[31:25]; valid_d = 1'b1;
  endtask

  task automatic bump_cnt();
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_e = 1'b0; zero_e = 1'b1; lt_e = 1'b1;
    set_ins(32'h00B50533);
    step(); step();
    ntotal++; if (reg_write_e !== 1'b0) $display("FAIL rst_rw_e got %0b want 0", reg_write_e); else npass++;
    ntotal++; if (reg_write_m !== 1'b0) $display("FAIL rst_rw_m got %0b want 0", reg_write_m); else npass++;
    ntotal++; if (reg_write_w !== 1'b0) $display("FAIL rst_rw_w got %0b want 0", reg_write_w); else npass++;
    ntotal++; if (pc_src_e !== 1'b0) $display("FAIL rst_pc_src got %0b want 0", pc_src_e); else npass++;
    ntotal++; if (illegal_cnt !== 8'd0) $display("FAIL rst_cnt got %0d want 0", illegal_cnt); else npass++;
    ntotal++; if (result_src_w !== 2'b00) $display("FAIL rst_rs_w got %0b want 00", result_src_w); else npass++;
    rst_n = 1'b1; zero_e = 1'b0; lt_e = 1'b0;
  endtask

  task automatic test_pipeline();
    set_ins(32'h00B50533);
    #1;
    ntotal++; if (illegal_d !== 1'b0) $display("FAIL pipe_illegal got %0b want 0", illegal_d); else npass++;
    step();
    ntotal++; if (reg_write_e !== 1'b1) $display("FAIL pipe_rw_e got %0b want 1", reg_write_e); else npass++;
    ntotal++; if (alu_ctl_e !== 4'd0) $display("FAIL pipe_alu_e got %0d want 0", alu_ctl_e); else npass++;
    ntotal++; if (alu_src_e !== 1'b0) $display("FAIL pipe_as_e got %0b want 0", alu_src_e); else npass++;
    valid_d = 1'b0;
    step();
    ntotal++; if (reg_write_m !== 1'b1) $display("FAIL pipe_rw_m got %0b want 1", reg_write_m); else npass++;
    ntotal++; if (reg_write_e !== 1'b0) $display("FAIL pipe_bubble_e got %0b want 0", reg_write_e); else npass++;
    step();
    ntotal++; if (reg_write_w !== 1'b1) $display("FAIL pipe_rw_w got %0b want 1", reg_write_w); else npass++;
    ntotal++; if (result_src_w !== 2'b00) $display("FAIL pipe_rs_w got %0b want 00", result_src_w); else npass++;
    ntotal++; if (reg_write_m !== 1'b0) $display("FAIL pipe_bubble_m got %0b want 0", reg_write_m); else npass++;
  endtask

  task automatic test_decode();
    logic [31:0] vi [12];
    logic [3:0]  va [12];
    logic [2:0]  vm [12];
    logic        vs [12];
    logic        vr [12];
    logic        vl [12];
    // instr, alu_ctl, imm_src, alu_src, reg_write, illegal
    vi[0]  = 32'h40B50533; va[0]  = 4'd1;  vm[0]  = 3'd0; vs[0]  = 0; vr[0]  = 1; vl[0]  = 0; // sub
    vi[1]  = 32'h40B55533; va[1]  = 4'd9;  vm[1]  = 3'd0; vs[1]  = 0; vr[1]  = 1; vl[1]  = 0; // sra
    vi[2]  = 32'h40355513; va[2]  = 4'd9;  vm[2]  = 3'd0; vs[2]  = 1; vr[2]  = 1; vl[2]  = 0; // srai
    vi[3]  = 32'h40351513; va[3]  = 4'd0;  vm[3]  = 3'd0; vs[3]  = 0; vr[3]  = 0; vl[3]  = 1; // slli bad f7
    vi[4]  = 32'h00353513; va[4]  = 4'd6;  vm[4]  = 3'd0; vs[4]  = 1; vr[4]  = 1; vl[4]  = 0; // sltiu
    vi[5]  = 32'h12345537; va[5]  = 4'd10; vm[5]  = 3'd3; vs[5]  = 1; vr[5]  = 1; vl[5]  = 0; // lui
    vi[6]  = 32'h00A5A023; va[6]  = 4'd0;  vm[6]  = 3'd1; vs[6]  = 1; vr[6]  = 0; vl[6]  = 0; // sw
    vi[7]  = 32'h00050503; va[7]  = 4'd0;  vm[7]  = 3'd0; vs[7]  = 0; vr[7]  = 0; vl[7]  = 1; // lb
    vi[8]  = 32'h00B56463; va[8]  = 4'd0;  vm[8]  = 3'd0; vs[8]  = 0; vr[8]  = 0; vl[8]  = 1; // bltu
    vi[9]  = 32'h04B50533; va[9]  = 4'd0;  vm[9]  = 3'd0; vs[9]  = 0; vr[9]  = 0; vl[9]  = 1; // R bad f7
    vi[10] = 32'h008000EF; va[10] = 4'd0;  vm[10] = 3'd4; vs[10] = 0; vr[10] = 1; vl[10] = 0; // jal
    vi[11] = 32'h00B54533; va[11] = 4'd4;  vm[11] = 3'd0; vs[11] = 0; vr[11] = 1; vl[11] = 0; // xor
    for (int i = 0; i < 12; i++) begin
      set_ins(vi[i]);
      #1;
      ntotal++; if (illegal_d !== vl[i]) $display("FAIL dec%0d_illegal got %0b want %0b", i, illegal_d, vl[i]); else npass++;
      ntotal++; if (imm_src_d !== vm[i]) $display("FAIL dec%0d_imm got %0d want %0d", i, imm_src_d, vm[i]); else npass++;
      if (vl[i]) bump_cnt();
      step();
      ntotal++; if (alu_ctl_e !== va[i]) $display("FAIL dec%0d_alu got %0d want %0d", i, alu_ctl_e, va[i]); else npass++;
      ntotal++; if (alu_src_e !== vs[i]) $display("FAIL dec%0d_as got %0b want %0b", i, alu_src_e, vs[i]); else npass++;
      ntotal++; if (reg_write_e !== vr[i]) $display("FAIL dec%0d_rw got %0b want %0b", i, reg_write_e, vr[i]); else npass++;
      ntotal++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL dec%0d_cnt got %0d want %0d", i, illegal_cnt, exp_cnt); else npass++;
    end
    // the sw from vector 6 has reached M by now? no: check a fresh store walking to M
    set_ins(32'h00A5A023);
    step();
    ntotal++; if (mem_write_e !== 1'b1) $display("FAIL sw_mw_e got %0b want 1", mem_write_e); else npass++;
    valid_d = 1'b0;
    step();
    ntotal++; if (mem_write_m !== 1'b1) $display("FAIL sw_mw_m got %0b want 1", mem_write_m); else npass++;
    ntotal++; if (reg_write_m !== 1'b0) $display("FAIL sw_rw_m got %0b want 0", reg_write_m); else npass++;
  endtask

  task automatic test_branch();
    zero_e = 1'b1; lt_e = 1'b0;
    set_ins(32'h00B50463); // beq
    step();
    ntotal++; if (pc_src_e !== 1'b1) $display("FAIL beq_taken got %0b want 1", pc_src_e); else npass++;
    ntotal++; if (alu_ctl_e !== 4'd1) $display("FAIL beq_alu got %0d want 1", alu_ctl_e); else npass++;
    ntotal++; if (reg_write_e !== 1'b0) $display("FAIL beq_rw got %0b want 0", reg_write_e); else npass++;
    set_ins(32'h00B51463); // bne
    step();
    ntotal++; if (pc_src_e !== 1'b0) $display("FAIL bne_zero got %0b want 0", pc_src_e); else npass++;
    zero_e = 1'b0;
    #1;
    ntotal++; if (pc_src_e !== 1'b1) $display("FAIL bne_nonzero got %0b want 1", pc_src_e); else npass++;
    set_ins(32'h00B54463); // blt
    step();
    ntotal++; if (pc_src_e !== 1'b0) $display("FAIL blt_nlt got %0b want 0", pc_src_e); else npass++;
    set_ins(32'h00B55463); // bge
    step();
    ntotal++; if (pc_src_e !== 1'b1) $display("FAIL bge_nlt got %0b want 1", pc_src_e); else npass++;
    set_ins(32'h008000EF); // jal
    step();
    ntotal++; if (pc_src_e !== 1'b1) $display("FAIL jal_pc got %0b want 1", pc_src_e); else npass++;
    ntotal++; if (result_src_e !== 2'b10) $display("FAIL jal_rs got %0b want 10", result_src_e); else npass++;
    ntotal++; if (jalr_e !== 1'b0) $display("FAIL jal_jalr got %0b want 0", jalr_e); else npass++;
    set_ins(32'h000500E7); // jalr
    step();
    ntotal++; if (jalr_e !== 1'b1) $display("FAIL jalr_flag got %0b want 1", jalr_e); else npass++;
    ntotal++; if (pc_src_e !== 1'b1) $display("FAIL jalr_pc got %0b want 1", pc_src_e); else npass++;
    valid_d = 1'b0;
    step();
    ntotal++; if (pc_src_e !== 1'b0) $display("FAIL bubble_pc got %0b want 0", pc_src_e); else npass++;
  endtask

  task automatic test_flush();
    set_ins(32'h0005A503); // lw
    flush_e = 1'b1;
    step();
    flush_e = 1'b0; valid_d = 1'b0;
    ntotal++; if (reg_write_e !== 1'b0) $display("FAIL flush_rw_e got %0b want 0", reg_write_e); else npass++;
    ntotal++; if (result_src_e !== 2'b00) $display("FAIL flush_rs_e got %0b want 00", result_src_e); else npass++;
    ntotal++; if (alu_src_e !== 1'b0) $display("FAIL flush_as_e got %0b want 0", alu_src_e); else npass++;
    step();
    ntotal++; if (reg_write_m !== 1'b0) $display("FAIL flush_rw_m got %0b want 0", reg_write_m); else npass++;
    ntotal++; if (result_src_m !== 2'b00) $display("FAIL flush_rs_m got %0b want 00", result_src_m); else npass++;
    step();
    ntotal++; if (reg_write_w !== 1'b0) $display("FAIL flush_rw_w got %0b want 0", reg_write_w); else npass++;
    set_ins(32'h00A5A023); // sw flushed
    flush_e = 1'b1;
    step();
    flush_e = 1'b0; valid_d = 1'b0;
    ntotal++; if (mem_write_e !== 1'b0) $display("FAIL flush_mw_e got %0b want 0", mem_write_e); else npass++;
    step();
    ntotal++; if (mem_write_m !== 1'b0) $display("FAIL flush_mw_m got %0b want 0", mem_write_m); else npass++;
  endtask

  task automatic test_muldiv();
    set_ins(32'h02B50533); // mul
    #1;
`ifdef RV_MULDIV_EN
    ntotal++; if (illegal_d !== 1'b0) $display("FAIL mul_illegal got %0b want 0", illegal_d); else npass++;
    step();
    ntotal++; if (alu_ctl_e !== 4'd11) $display("FAIL mul_alu got %0d want 11", alu_ctl_e); else npass++;
`else
    ntotal++; if (illegal_d !== 1'b1) $display("FAIL mul_illegal got %0b want 1", illegal_d); else npass++;
    bump_cnt();
    step();
    ntotal++; if (alu_ctl_e !== 4'd0) $display("FAIL mul_alu got %0d want 0", alu_ctl_e); else npass++;
`endif
    ntotal++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL mul_cnt got %0d want %0d", illegal_cnt, exp_cnt); else npass++;
    valid_d = 1'b0;
  endtask

  task automatic test_illegal();
    op = 7'h7F; funct3 = 3'b000; funct7 = 7'b0000000; valid_d = 1'b1;
    for (int i = 0; i < 260; i++) begin
      flush_e = (i < 5);
      #1;
      ntotal++; if (illegal_d !== 1'b1) $display("FAIL ill%0d_flag got %0b want 1", i, illegal_d); else npass++;
      ntotal++; if (imm_src_d !== 3'd0) $display("FAIL ill%0d_imm got %0d want 0", i, imm_src_d); else npass++;
      bump_cnt();
      step();
      ntotal++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL ill%0d_cnt got %0d want %0d", i, illegal_cnt, exp_cnt); else npass++;
      ntotal++; if (reg_write_e !== 1'b0) $display("FAIL ill%0d_rw got %0b want 0", i, reg_write_e); else npass++;
    end
    flush_e = 1'b0;
    ntotal++; if (illegal_cnt !== 8'd255) $display("FAIL ill_sat got %0d want 255", illegal_cnt); else npass++;
  endtask

  task automatic test_reset_midstream();
    set_ins(32'h00B50533);
    step(); step();
    ntotal++; if (reg_write_m !== 1'b1) $display("FAIL mid_pre_rw_m got %0b want 1", reg_write_m); else npass++;
    op = 7'h7F; rst_n = 1'b0; flush_e = 1'b1;
    step();
    ntotal++; if (illegal_cnt !== 8'd0) $display("FAIL mid_cnt got %0d want 0", illegal_cnt); else npass++;
    ntotal++; if (reg_write_m !== 1'b0) $display("FAIL mid_rw_m got %0b want 0", reg_write_m); else npass++;
    ntotal++; if (reg_write_w !== 1'b0) $display("FAIL mid_rw_w got %0b want 0", reg_write_w); else npass++;
    ntotal++; if (reg_write_e !== 1'b0) $display("FAIL mid_rw_e got %0b want 0", reg_write_e); else npass++;
    rst_n = 1'b1; flush_e = 1'b0; valid_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_decode();
    test_branch();
    test_flush();
    test_muldiv();
    test_illegal();
    test_reset_midstream();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/rv_ctrl_pipe.md
Name: rv_ctrl_pipe

Overview:
- Parametrised successor to the single-stage decode controller for the 5-stage RV32I core.
- Decodes op/funct3/funct7 in Decode (D) into the full control bundle, including ALU control.
- Carries that bundle through the E, M and W pipeline registers, with bubble insertion and branch resolution in E.
- Flags illegal encodings and keeps a saturating illegal-instruction counter for debug.

Parameters:
- IMMSRC_W, 3, width of imm_src_d (immediate-generator select).
- ALUCTL_W, 4, width of ALU control code; must be >= 4.
- CNT_W, 8, width of illegal_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_d  in  1  D-stage instruction is real (0 = bubble)
- op  in  7  instr[6:0] in D
- funct3  in  3  instr[14:12] in D
- funct7  in  7  instr[31:25] in D
- flush_e  in  1  from hazard unit: load bubble into E next edge
- zero_e  in  1  ALU result == 0 (E)
- lt_e  in  1  ALU signed less-than (E)
- imm_src_d  out  IMMSRC_W  comb: I=0, S=1, B=2, U=3, J=4
- illegal_d  out  1  comb: valid_d and encoding unsupported
- reg_write_e/m/w  out  1 each  register-file write enable per stage
- result_src_e/m/w  out  2 each  00 ALU, 01 mem, 10 PC+4
- mem_write_e/m  out  1 each  data-memory write enable
- alu_src_e  out  1  0 = rs2, 1 = immediate
- alu_ctl_e  out  ALUCTL_W  ALU operation code
- jalr_e  out  1  target = rs1 + imm
- pc_src_e  out  1  redirect PC
- illegal_cnt  out  CNT_W  saturating count of illegal instructions

Behaviour:
- Decoded opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- Any other opcode is illegal.
- LW/SW with funct3 != 010 are illegal.
- B with funct3 in {010, 011, 110, 111} is illegal.
- An illegal instruction, or valid_d = 0, produces an all-zero bundle with imm_src_d = 0.
- ALU codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB (LUI).
  - R-type: sub when funct7[5] = 1 and funct3 = 000.
  - sra when funct7[5] = 1 and funct3 = 101.
  - R-type with funct7 other than 0000000 or 0100000 is illegal.
  - I-ALU: funct7[5] is used only for srai; slli/srli/srai require funct7 = 0000000 or 0100000 (0100000 only for srai).
  - LW, SW, JALR use add; B uses sub.
- Stage registers:
  - D->E captures the decoded bundle plus funct3[2:0] as br_cond_e. E->M and M->W forward their subsets.
  - Latency is one cycle per stage: a bundle visible in D at edge N appears at *_e after N, *_m after N+1, *_w after N+2.
  - No stall input; the hazard unit stalls by holding the D register upstream and asserting flush_e.
- flush_e = 1: all E-stage registers load 0 next edge; M and W still advance. The flushed bundle never reaches M.
- Branch resolution, with branch_e internal:
  - taken = beq: zero_e; bne: !zero_e; blt: lt_e; bge: !lt_e.
  - pc_src_e = jump_e | (branch_e & taken). This is combinational from E registers and flags.
- illegal_cnt: increments on an edge where illegal_d = 1; holds at all-ones, with no wrap. illegal_d is not gated by flush_e.
- Reset (rst_n = 0 at an edge): every E/M/W register and illegal_cnt go to 0, so all *_e/m/w outputs are 0 and pc_src_e = 0.
  - Reset mid-stream discards all in-flight bundles.
  - Reset has priority over flush_e and counting.

Optional Feature:
- Macro RV_MULDIV_EN.
- Defined:
  - R-type with funct7 = 0000001 decodes to mul (11), mulh (12), div (13), rem (14) for funct3 000, 001, 100, 110.
  - All other funct3 values with funct7 = 0000001 are illegal.
- Undefined: funct7 = 0000001 is illegal. Codes 11-14 are never produced.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with valid R-type add at D -> all *_e/m/w = 0, pc_src_e = 0, illegal_cnt = 0; release.
- Pipeline: add (0x00B50533) at D on cycle 1 -> reg_write_e = 1, alu_ctl_e = 0 after edge 1; reg_write_m = 1 after edge 2; reg_write_w = 1, result_src_w = 00 after edge 3.
- Branch: beq (0x00B50463) then bne in consecutive cycles with zero_e = 1 -> pc_src_e = 1 for beq, 0 for bne; blt with lt_e = 0 -> 0.
- Flush: lw at D, flush_e = 1 on the same edge -> *_e all 0 next cycle; mem/reg writes never appear in M or W.
- Illegal: op = 0x7F for 260 consecutive cycles (CNT_W = 8) -> illegal_d = 1, bundle 0, illegal_cnt saturates at 255.
- Mul/div: mul (funct7 = 0000001, funct3 = 000) -> with RV_MULDIV_EN, alu_ctl_e = 11 and illegal_d = 0; without it, illegal_d = 1 and the count increments.
